// File: rtl/mul24_iter.sv
// mul24_iter: iterative 24x24 -> 48 bit unsigned mantissa multiplier (IDLE/RUN/DONE).
// Latency: N+1 edges after the accepting edge (N=12 with MUL24_RADIX4_EN defined, N=24 otherwise).
// Backpressure: stall holds the issuing stage while a request is accepted or RUN is active; ena=0 freezes all state.
module mul24_iter (
  input  logic        clk,
  input  logic        clr,
  input  logic [23:0] a,
  input  logic [23:0] b,
  input  logic        fmul,
  input  logic        ena,
  output logic [47:0] q,
  output logic        busy,
  output logic [4:0]  count,
  output logic        stall
);

`ifdef MUL24_RADIX4_EN
  localparam int unsigned DIGW = 2;
  localparam logic [4:0]  LAST = 5'd11;
`else
  localparam int unsigned DIGW = 1;
  localparam logic [4:0]  LAST = 5'd23;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q;
  logic [23:0] a_q;
  logic [23:0] b_q;
  logic [47:0] acc_q;
  logic [47:0] q_q;
  logic        busy_q;
  logic [4:0]  count_q;
`ifdef MUL24_RADIX4_EN
  logic [25:0] a3_q;
`endif

  logic [47:0] pp_ext;
  logic [47:0] pp_shift;

  // Partial product for the current multiplier digit, aligned to its digit position.
  always_comb begin
    pp_ext   = '0;
    pp_shift = '0;
`ifdef MUL24_RADIX4_EN
    case (b_q[1:0])
      2'd1:    pp_ext = {24'd0, a_q};
      2'd2:    pp_ext = {23'd0, a_q, 1'b0};
      2'd3:    pp_ext = {22'd0, a3_q};
      default: pp_ext = '0;
    endcase
    pp_shift = pp_ext << {count_q, 1'b0};
`else
    if (b_q[0]) begin
      pp_ext = {24'd0, a_q};
    end
    pp_shift = pp_ext << count_q;
`endif
  end

  // Control FSM and datapath registers. A clear while an operation is in
  // flight aborts it but leaves the last delivered product on q; a clear
  // from IDLE is a full reset and also zeroes q.
  always_ff @(posedge clk) begin
    if (clr) begin
      if (state_q == IDLE) begin
        q_q <= '0;
      end
      state_q <= IDLE;
      busy_q  <= 1'b0;
      count_q <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
`ifdef MUL24_RADIX4_EN
      a3_q    <= '0;
`endif
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          if (fmul) begin
            a_q     <= a;
            b_q     <= b;
`ifdef MUL24_RADIX4_EN
            a3_q    <= {2'b00, a} + {1'b0, a, 1'b0};
`endif
            acc_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q   <= acc_q + pp_shift;
          b_q     <= b_q >> DIGW;
          count_q <= count_q + 5'd1;
          if (count_q == LAST) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          q_q     <= acc_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall = (state_q == RUN) || ((state_q == IDLE) && fmul && ena);
  assign q     = q_q;
  assign busy  = busy_q;
  assign count = count_q;

endmodule

// File: tb/tb_mul24_iter.sv
// tb_mul24_iter: random and directed operations against a plain a*b reference and a cycle-count timeline.
// Same bench covers both digit widths; MUL24_RADIX4_EN selects the expected iteration count.
module tb_mul24_iter;

`ifdef MUL24_RADIX4_EN
  localparam int N = 12;
`else
  localparam int N = 24;
`endif

  logic        clk;
  logic        clr;
  logic [23:0] a;
  logic [23:0] b;
  logic        fmul;
  logic        ena;
  logic [47:0] q;
  logic        busy;
  logic [4:0]  count;
  logic        stall;

  int          n_vec;
  int          n_err;
  logic [47:0] prev_q;

  mul24_iter dut (
    .clk   (clk),
    .clr   (clr),
    .a     (a),
    .b     (b),
    .fmul  (fmul),
    .ena   (ena),
    .q     (q),
    .busy  (busy),
    .count (count),
    .stall (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One full operation. Entered and left #1 after an edge with the DUT in IDLE.
  // Operands and fmul are scrambled while RUN/DONE to show they are ignored.
  task automatic do_op(input logic [23:0] av, input logic [23:0] bv,
                       input int frz_at, input int frz_len, input bit keep);
    logic [47:0] exp_p;
    int          m;
    int          left;
    bit          en_prev;
    exp_p = {24'd0, av} * {24'd0, bv};
    a = av; b = bv; fmul = 1'b1; ena = 1'b1;
    #1;
    chk("req_stall", 48'(stall), 48'd1);
    chk("req_busy", 48'(busy), 48'd0);
    m    = 0;
    left = frz_len;
    while (m < N + 1) begin
      en_prev = ena;
      @(posedge clk); #1;
      if (en_prev) m++;
      chk("run_busy", 48'(busy), 48'd1);
      if (m <= N) chk("run_count", 48'(count), 48'(m - 1));
      chk("run_stall", 48'(stall), (m <= N) ? 48'd1 : 48'd0);
      chk("q_hold", q, prev_q);
      a    = 24'($urandom);
      b    = 24'($urandom);
      fmul = (m == N + 1) ? keep : 1'($urandom_range(0, 1));
      if (m == frz_at && left > 0) begin
        ena = 1'b0;
        left--;
      end else begin
        ena = 1'b1;
      end
    end
    @(posedge clk); #1;
    chk("product", q, exp_p);
    chk("done_busy", 48'(busy), 48'd0);
    chk("idle_stall", 48'(stall), keep ? 48'd1 : 48'd0);
    prev_q = exp_p;
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    prev_q = '0;
    clr = 1'b1; ena = 1'b0; fmul = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", q, 48'd0);
    chk("rst_busy", 48'(busy), 48'd0);
    chk("rst_count", 48'(count), 48'd0);
    chk("rst_stall", 48'(stall), 48'd0);
    clr = 1'b0; ena = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 48'(busy), 48'd0);

    // Directed operands, including the spec product constants.
    do_op(24'hC00000, 24'h800000, 0, 0, 1'b0);
    chk("basic_const", q, 48'h600000000000);
    do_op(24'hFFFFFF, 24'hFFFFFF, 0, 0, 1'b0);
    chk("max_const", q, 48'hFFFFFE000001);
    do_op(24'h000000, 24'hABCDEF, 0, 0, 1'b0);
    chk("zero_const", q, 48'h000000000000);
    // Five frozen cycles mid-RUN.
    do_op(24'h123456, 24'hFEDCBA, 4, 5, 1'b0);
    // Back-to-back with fmul held through DONE.
    do_op(24'h800000, 24'h800000, 0, 0, 1'b1);
    chk("b2b_const", q, 48'h400000000000);
    do_op(24'hA5A5A5, 24'h5A5A5A, 0, 0, 1'b0);

    // Abort mid-RUN with clr while ena is low: clr wins, q keeps last product.
    a = 24'h777777; b = 24'h999999; fmul = 1'b1; ena = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    chk("abort_pre_count", 48'(count), 48'd6);
    clr = 1'b1; ena = 1'b0; fmul = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", 48'(busy), 48'd0);
    chk("abort_count", 48'(count), 48'd0);
    chk("abort_q", q, prev_q);
    chk("abort_stall", 48'(stall), 48'd0);
    fmul = 1'b1; ena = 1'b1; #1;
    chk("abort_stall_req", 48'(stall), 48'd1);
    clr = 1'b0; fmul = 1'b0;
    @(posedge clk); #1;
    chk("post_abort_busy", 48'(busy), 48'd0);

    // Request with ena low in IDLE is neither stalled nor accepted.
    fmul = 1'b1; ena = 1'b0; #1;
    chk("frz_idle_stall", 48'(stall), 48'd0);
    @(posedge clk); #1;
    chk("frz_idle_busy", 48'(busy), 48'd0);
    fmul = 1'b0; ena = 1'b1;
    @(posedge clk); #1;

    // Random operations, random freezes, random back-to-back.
    for (int i = 0; i < 20; i++) begin
      do_op(24'($urandom), 24'($urandom), $urandom_range(1, N),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
